jk_using_d: RTL and testbench
=============================

Name: jk_using_d

Overview:
- JK flip-flop bank built from a D-type storage element plus next-state logic, where D = (J & ~Q) | (~K & Q).
- Provides the classic hold/set/reset/toggle behaviour on the rising clock edge, with an asynchronous active-low clear.
- Used as a generic control/state bit (or WIDTH-bit bank of independent bits) in sequential logic.

Parameters:
- WIDTH, 1, number of independent JK bits; every bit uses the same clock and reset.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q while reset is asserted.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; Q is forced to RESET_VAL immediately on assertion.
- J  input  WIDTH  per-bit set/toggle request.
- K  input  WIDTH  per-bit reset/toggle request.
- Q  output  WIDTH  registered state.
- Q_n  output  WIDTH  combinational bitwise complement of Q.

Behaviour:
- Storage: one WIDTH-bit D register. Its D input is driven only by the next-state function; there is no other path into the register.
- Next-state per bit i, evaluated from J, K and the current Q, then captured on posedge clk:
  - J=0, K=0 -> hold (Q unchanged).
  - J=1, K=0 -> set (Q becomes 1).
  - J=0, K=1 -> reset (Q becomes 0).
  - J=1, K=1 -> toggle (Q becomes ~Q).
- Latency: J/K values present at a rising edge are reflected on Q after that edge. Q is stable between edges, and J/K changes between edges have no effect.
- Reset:
  - rst_n=0 forces Q=RESET_VAL (default 0) and Q_n=~RESET_VAL immediately, independent of clk.
  - Q holds that value while rst_n stays low, and clock edges are ignored.
- Reset release:
  - The first rising edge with rst_n=1 applies the normal JK function starting from RESET_VAL.
  - Example: J=K=1 at the first edge after release gives Q=1 when RESET_VAL=0.
- Reset mid-operation: asserting rst_n between edges clears Q at once, with no waiting for a clock edge. Any pending J/K is discarded.
- Q_n: always the exact complement of Q, including during reset. No extra register stage.
- Bits are fully independent; there is no interaction between bit i and bit j.
- Unknown inputs: X on J/K at an edge may propagate X into Q. No X-suppression is required.
- Power-up: Q is undefined until the first rst_n assertion. Benches must assert reset before checking Q.
- No glitching requirement on Q beyond what a single flop gives. Q changes only on a rising edge or on reset assertion.

Test Plan:
Benches drive J/K on the falling edge of clk (10-unit period) and check Q after each rising edge. WIDTH=1 unless stated.
- Reset: rst_n=0 with J=1, K=1 while clk toggles for 3 cycles -> Q=0 and Q_n=1 throughout. Deassert rst_n, hold J=K=0 -> Q stays 0.
- Set then hold:
  - J=1, K=0 for one edge -> Q=1.
  - Then J=0, K=0 for two edges -> Q remains 1.
- Reset input: from Q=1, J=0, K=1 for one edge -> Q=0, Q_n=1.
- Toggle: from Q=0, J=1, K=1 for four consecutive edges -> Q sequence 1,0,1,0.
- Async reset mid-cycle: with Q=1, pull rst_n low midway between edges -> Q=0 before the next rising edge. Release, then J=1, K=0 for one edge -> Q=1.
- WIDTH=4, RESET_VAL=4'b1010:
  - Reset -> Q=1010.
  - J=0011, K=0101 for one edge -> Q=1011 (bit0 toggle, bit1 set, bit2 reset, bit3 hold).

Source files
------------

// File: rtl/jk_using_d.sv
// jk_using_d: a bank of WIDTH independent JK flip-flops.
// Each bit is stored in a plain D register. The register's D input is
// driven only by the JK next-state function D = (J & ~Q) | (~K & Q).
// That function gives hold, set, reset and toggle behaviour.
// rst_n is an asynchronous active-low clear that loads RESET_VAL.
// Q_n is the combinational complement of Q and has no register of its own.

module jk_using_d #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] J,
   input  logic [WIDTH-1:0] K,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_n
);

   logic [WIDTH-1:0] d_next;

   // JK next-state function, evaluated bitwise from J, K and the current Q.
   always_comb begin
      d_next = (J & ~Q) | (~K & Q);
   end

   // D storage: loads RESET_VAL asynchronously, otherwise captures d_next on the rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Q <= RESET_VAL;
      end else begin
         Q <= d_next;
      end
   end

   assign Q_n = ~Q;

endmodule

// File: tb/tb_jk_using_d.sv
// tb_jk_using_d: self-checking bench for jk_using_d.
// It drives a WIDTH=1 instance and a WIDTH=4 instance with RESET_VAL=4'b1010.
// Both instances share one clock and one reset.
// The stimulus process pushes hand-computed expected values into a queue.
// A separate monitor process pops each entry and compares it with the DUT outputs.

module tb_jk_using_d;

   typedef struct {
      string      tag;
      logic       exp_1;
      logic [3:0] exp_4;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       j1, k1;
   logic [3:0] j4, k4;
   logic       q1, qn1;
   logic [3:0] q4, qn4;

   exp_t exp_q[$];
   event check_ev;
   int   vectors;
   int   miscompares;

   jk_using_d #(
      .WIDTH     (1),
      .RESET_VAL (1'b0)
   ) dut_1 (
      .clk   (clk),
      .rst_n (rst_n),
      .J     (j1),
      .K     (k1),
      .Q     (q1),
      .Q_n   (qn1)
   );

   jk_using_d #(
      .WIDTH     (4),
      .RESET_VAL (4'b1010)
   ) dut_4 (
      .clk   (clk),
      .rst_n (rst_n),
      .J     (j4),
      .K     (k4),
      .Q     (q4),
      .Q_n   (qn4)
   );

   // 10-unit clock period. The first rising edge is at time 5.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Queue an expected value and wake the monitor.
   task automatic expect_now(input string tag, input logic e1, input logic [3:0] e4);
      exp_t e;
      e.tag   = tag;
      e.exp_1 = e1;
      e.exp_4 = e4;
      exp_q.push_back(e);
      -> check_ev;
   endtask

   // Drive J/K on the falling edge, then queue the expected value 1 unit after the next rising edge.
   task automatic apply_stimulus(input logic j, input logic k,
                                 input logic [3:0] jw, input logic [3:0] kw,
                                 input string tag, input logic e1, input logic [3:0] e4);
      @(negedge clk);
      j1 = j;
      k1 = k;
      j4 = jw;
      k4 = kw;
      @(posedge clk);
      #1;
      expect_now(tag, e1, e4);
   endtask

   // Compare one queued expectation against both DUTs, including the Q_n complements.
   task automatic check_output(input exp_t e);
      logic [9:0] act;
      logic [9:0] req;
      act = {q1, qn1, q4, qn4};
      req = {e.exp_1, ~e.exp_1, e.exp_4, ~e.exp_4};
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got q1=%b qn1=%b q4=%b qn4=%b, required q1=%b qn1=%b q4=%b qn4=%b",
                  e.tag, q1, qn1, q4, qn4, e.exp_1, ~e.exp_1, e.exp_4, ~e.exp_4);
      end
   endtask

   // Monitor: drains the scoreboard each time the stimulus flags that outputs are ready.
   initial begin
      forever begin
         @(check_ev);
         while (exp_q.size() > 0) begin
            check_output(exp_q.pop_front());
         end
      end
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n = 1'b1;
      j1 = 1'b1;
      k1 = 1'b1;
      j4 = 4'b1111;
      k4 = 4'b1111;

      // Assert reset between edges. Q must clear at once.
      #2;
      rst_n = 1'b0;
      #1;
      expect_now("reset_immediate", 1'b0, 4'b1010);

      // Hold reset with J=K=1 for 3 clock cycles. Q must stay at the reset value.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         expect_now("reset_hold", 1'b0, 4'b1010);
      end

      // Release reset with J=K=0. Q stays at the reset value.
      @(negedge clk);
      rst_n = 1'b1;
      j1 = 1'b0;
      k1 = 1'b0;
      j4 = 4'b0000;
      k4 = 4'b0000;
      @(posedge clk);
      #1;
      expect_now("release_hold", 1'b0, 4'b1010);

      // Set, then hold for two edges.
      apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000, "set", 1'b1, 4'b1010);
      apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000, "hold_1", 1'b1, 4'b1010);
      apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000, "hold_2", 1'b1, 4'b1010);

      // A J/K change between edges must not affect Q before the next edge.
      @(negedge clk);
      j1 = 1'b0;
      k1 = 1'b1;
      #3;
      expect_now("no_effect_between_edges", 1'b1, 4'b1010);

      // The reset input (J=0, K=1) takes effect at the edge.
      @(posedge clk);
      #1;
      expect_now("reset_input", 1'b0, 4'b1010);

      // Toggle for four edges starting from Q=0.
      apply_stimulus(1'b1, 1'b1, 4'b0000, 4'b0000, "toggle_1", 1'b1, 4'b1010);
      apply_stimulus(1'b1, 1'b1, 4'b0000, 4'b0000, "toggle_2", 1'b0, 4'b1010);
      apply_stimulus(1'b1, 1'b1, 4'b0000, 4'b0000, "toggle_3", 1'b1, 4'b1010);
      apply_stimulus(1'b1, 1'b1, 4'b0000, 4'b0000, "toggle_4", 1'b0, 4'b1010);

      // Set Q=1 and move the wide bank away from its reset value.
      // Wide bank: bit0 toggles, bit1 sets, bit2 resets, bit3 holds, giving 1010 -> 1011.
      apply_stimulus(1'b1, 1'b0, 4'b0011, 4'b0101, "set_and_wide_mix", 1'b1, 4'b1011);

      // Wide bank: toggle all bits, 1011 -> 0100.
      apply_stimulus(1'b0, 1'b0, 4'b1111, 4'b1111, "wide_toggle_all", 1'b1, 4'b0100);

      // Assert reset between edges. Both banks clear before the next rising edge.
      #2;
      rst_n = 1'b0;
      #1;
      expect_now("async_reset_mid", 1'b0, 4'b1010);

      // Release reset, then set for one edge.
      @(negedge clk);
      rst_n = 1'b1;
      j1 = 1'b1;
      k1 = 1'b0;
      j4 = 4'b0000;
      k4 = 4'b0000;
      @(posedge clk);
      #1;
      expect_now("set_after_release", 1'b1, 4'b1010);

      // The first edge after release with J=K=1 toggles from the reset value.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      expect_now("reset_again", 1'b0, 4'b1010);
      @(negedge clk);
      rst_n = 1'b1;
      j1 = 1'b1;
      k1 = 1'b1;
      j4 = 4'b1111;
      k4 = 4'b1111;
      @(posedge clk);
      #1;
      expect_now("toggle_first_edge", 1'b1, 4'b0101);

      // Let the monitor drain. Any entry left in the queue counts as a miscompare.
      #5;
      if (exp_q.size() != 0) begin
         miscompares += exp_q.size();
         $display("[TB] FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
